// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad row/column pins plus the decoded key-event outputs.
// master is the scanner side, slave is the keypad/consumer side.
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    logic [COLS-1:0]              col_in;
    logic [ROWS-1:0]              row_out;
    logic                         key_valid;
    logic [$clog2(ROWS)-1:0]      key_row;
    logic [$clog2(COLS)-1:0]      key_col;
    logic [$clog2(ROWS*COLS)-1:0] key_code;
    logic                         key_held;
    logic                         multi_err;
    modport master (
        input  col_in,
        output row_out, key_valid, key_row, key_col, key_code, key_held, multi_err
    );
    modport slave (
        output col_in,
        input  row_out, key_valid, key_row, key_col, key_code, key_held, multi_err
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-by-row matrix keypad scan with debounce, single-key events,
// optional auto-repeat and multi-key rejection.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input logic             clk,
    input logic             reset,
    keypad_scanner_if.master kp
);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int KW   = $clog2(ROWS*COLS);
    localparam int SW   = $clog2(SETTLE_CYCLES);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int PW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state, state_n;
    logic [COLS-1:0] s1, cs;
    logic [RW-1:0]   ri, ri_n, ri_inc;
    logic [SW-1:0]   sc, sc_n;
    logic [DW-1:0]   dc, dc_n;
    logic [PW-1:0]   rc, rc_n, rc_inc, rc_lim;
    logic            rep, rep_n;
    logic [CW-1:0]   cand, cand_n, col_idx;
    logic            accept, valid_n, held_n, merr_n;

    assign kp.row_out = ROWS'(1) << ri;

    always_comb begin
        ri_inc  = (ri == R_LAST) ? '0 : ri + RW'(1);
        rc_lim  = rep ? PW'(REPEAT_RATE) : PW'(REPEAT_DELAY);
        rc_inc  = (rc == rc_lim) ? rc : rc + PW'(1);
        col_idx = '0;
        for (int i = 0; i < COLS; i++) if (cs[i]) col_idx = CW'(i);
        state_n = state;
        ri_n    = ri;
        sc_n    = sc;
        dc_n    = dc;
        rc_n    = rc;
        rep_n   = rep;
        cand_n  = cand;
        accept  = 1'b0;
        valid_n = 1'b0;
        merr_n  = 1'b0;
        held_n  = kp.key_held;
        case (state)
            SCAN: begin
                if (sc != S_LAST) sc_n = sc + SW'(1);
                else begin
                    sc_n = '0;
                    if ($onehot(cs)) begin
                        state_n = DEBOUNCE;
                        cand_n  = col_idx;
                        dc_n    = '0;
                    end else begin
                        ri_n   = ri_inc;
                        merr_n = |cs;
                    end
                end
            end
            DEBOUNCE: begin
                if (cs != (COLS'(1) << cand)) begin
                    state_n = SCAN;
                    ri_n    = ri_inc;
                end else if (dc == D_LAST) begin
                    state_n = HELD;
                    accept  = 1'b1;
                    valid_n = 1'b1;
                    held_n  = 1'b1;
                    rc_n    = '0;
                    rep_n   = 1'b0;
                end else dc_n = dc + DW'(1);
            end
            HELD: begin
                if (cs == '0) begin
                    state_n = RELEASE;
                    dc_n    = '0;
                end else if (REPEAT_EN != 0) begin
                    // First period uses REPEAT_DELAY, every later one REPEAT_RATE.
                    rc_n = rc_inc;
                    if (rc_inc == rc_lim) begin
                        valid_n = 1'b1;
                        rc_n    = '0;
                        rep_n   = 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (cs != '0) state_n = HELD;
                else if (dc == D_LAST) begin
                    state_n = SCAN;
                    ri_n    = ri_inc;
                    held_n  = 1'b0;
                end else dc_n = dc + DW'(1);
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SCAN;
            s1           <= '0;
            cs           <= '0;
            ri           <= '0;
            sc           <= '0;
            dc           <= '0;
            rc           <= '0;
            rep          <= 1'b0;
            cand         <= '0;
            kp.key_valid <= 1'b0;
            kp.key_row   <= '0;
            kp.key_col   <= '0;
            kp.key_code  <= '0;
            kp.key_held  <= 1'b0;
            kp.multi_err <= 1'b0;
        end else begin
            state        <= state_n;
            s1           <= kp.col_in;
            cs           <= s1;
            ri           <= ri_n;
            sc           <= sc_n;
            dc           <= dc_n;
            rc           <= rc_n;
            rep          <= rep_n;
            cand         <= cand_n;
            kp.key_valid <= valid_n;
            kp.key_held  <= held_n;
            kp.multi_err <= merr_n;
            if (accept) begin
                kp.key_row  <= ri;
                kp.key_col  <= cand;
                kp.key_code <= KW'(ri) * KW'(COLS) + KW'(cand);
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad into two scanners (repeat off/on)
// and checks key events against expectations derived from keypad behaviour.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          a_code[$], a_row[$], a_col[$], b_cyc[$], b_code[$];
    int          a_merr = 0;
    int          both_cnt = 0;

    keypad_scanner_if #(.ROWS(4), .COLS(4)) ifa ();
    keypad_scanner_if #(.ROWS(4), .COLS(4)) ifb ();

    keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(3), .DEBOUNCE_CYCLES(8),
        .REPEAT_EN(0), .REPEAT_DELAY(40), .REPEAT_RATE(10))
        dut_a (.clk(clk), .reset(reset), .kp(ifa));
    keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(3), .DEBOUNCE_CYCLES(8),
        .REPEAT_EN(1), .REPEAT_DELAY(40), .REPEAT_RATE(10))
        dut_b (.clk(clk), .reset(reset), .kp(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a driven row connects every pressed key of that row to its column.
    function automatic logic [3:0] cols_of(input logic [15:0] p, input logic [3:0] ro);
        logic [3:0] c;
        c = '0;
        for (int r = 0; r < 4; r++) if (ro[r]) c |= p[r*4 +: 4];
        return c;
    endfunction

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r*4 + c);
    endfunction

    always_comb ifa.col_in = cols_of(pressed, ifa.row_out);
    always_comb ifb.col_in = cols_of(pressed, ifb.row_out);

    always @(negedge clk) begin
        if (ifa.key_valid) begin
            a_code.push_back(int'(ifa.key_code));
            a_row.push_back(int'(ifa.key_row));
            a_col.push_back(int'(ifa.key_col));
        end
        if (ifb.key_valid) begin
            b_cyc.push_back(cyc);
            b_code.push_back(int'(ifb.key_code));
        end
        if (ifa.multi_err) a_merr++;
        if ((ifa.key_valid && ifa.multi_err) || (ifb.key_valid && ifb.multi_err)) both_cnt++;
    end

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ev(input int n, input int budget, output bit ok);
        ok = a_code.size() > n;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = a_code.size() > n;
        end
    endtask

    task automatic wait_held(input logic v, input int budget, output bit ok);
        ok = ifa.key_held == v;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = ifa.key_held == v;
        end
    endtask

    task automatic wait_row(input logic [3:0] r, input int budget, output bit ok);
        ok = ifa.row_out == r;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = ifa.row_out == r;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_row_out"}, int'(ifa.row_out), 1, 1);
        chk({nm, "_key_valid"}, int'(ifa.key_valid), 0, 0);
        chk({nm, "_key_held"}, int'(ifa.key_held), 0, 0);
        chk({nm, "_key_code"}, int'(ifa.key_code), 0, 0);
        chk({nm, "_key_row"}, int'(ifa.key_row), 0, 0);
        chk({nm, "_key_col"}, int'(ifa.key_col), 0, 0);
        chk({nm, "_multi_err"}, int'(ifa.multi_err), 0, 0);
    endtask

    typedef struct { int row; int col; int code; } vec_t;
    vec_t tbl[6];
    int   exp_off[5];

    initial begin
        int  k, kind, h, g, c2, n0, m0, nb0, ta, t0, bad;
        bit  ok;
        tbl[0] = '{0, 0, 0};
        tbl[1] = '{2, 1, 9};
        tbl[2] = '{1, 3, 7};
        tbl[3] = '{3, 3, 15};
        tbl[4] = '{0, 3, 3};
        tbl[5] = '{3, 0, 12};
        exp_off = '{0, 40, 50, 60, 70};

        ticks(3);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Idle: each row is driven for 3 cycles in rotation.
        n0 = a_code.size();
        m0 = a_merr;
        bad = 0;
        for (int n = 1; n <= 64; n++) begin
            tick();
            if (int'(ifa.row_out) != (1 << ((n / 3) % 4))) bad++;
        end
        chk("idle_row_errors", bad, 0, 0);
        chk("idle_events", a_code.size() - n0, 0, 0);
        chk("idle_multi_err", a_merr - m0, 0, 0);

        // Two keys in row 0 from reset: one multi_err per row-0 visit (at 3,15,27,39,51).
        reset = 1'b1;
        pressed = kbit(0, 0) | kbit(0, 2);
        ticks(2);
        reset = 1'b0;
        n0 = a_code.size();
        m0 = a_merr;
        ticks(60);
        chk("multi_err_pulses", a_merr - m0, 5, 5);
        chk("multi_events", a_code.size() - n0, 0, 0);
        pressed = '0;
        ticks(5);

        for (int i = 0; i < 6; i++) begin
            n0 = a_code.size();
            pressed = kbit(tbl[i].row, tbl[i].col);
            wait_ev(n0, 40, ok);
            chk("tbl_event_seen", int'(ok), 1, 1);
            if (ok) begin
                chk("tbl_code", a_code[n0], tbl[i].code, tbl[i].code);
                chk("tbl_row", a_row[n0], tbl[i].row, tbl[i].row);
                chk("tbl_col", a_col[n0], tbl[i].col, tbl[i].col);
            end
            chk("tbl_held", int'(ifa.key_held), 1, 1);
            ticks(10);
            chk("tbl_single_event", a_code.size() - n0, 1, 1);
            pressed = '0;
            t0 = cyc;
            wait_held(1'b0, 30, ok);
            chk("tbl_release_seen", int'(ok), 1, 1);
            chk("tbl_release_cycles", cyc - t0, 8, 14);
            chk("tbl_next_row", int'(ifa.row_out), 1 << ((tbl[i].row + 1) % 4), 1 << ((tbl[i].row + 1) % 4));
        end

        // First-press latency measured from entry into the key's row.
        wait_row(4'b1000, 20, ok);
        chk("lat_row3_seen", int'(ok), 1, 1);
        n0 = a_code.size();
        pressed = kbit(2, 1);
        wait_row(4'b0100, 20, ok);
        chk("lat_row2_seen", int'(ok), 1, 1);
        t0 = cyc;
        wait_ev(n0, 40, ok);
        chk("lat_event_seen", int'(ok), 1, 1);
        chk("lat_cycles", cyc - t0, 11, 13);
        pressed = '0;
        wait_held(1'b0, 30, ok);
        chk("lat_release_seen", int'(ok), 1, 1);

        // Bounce: row 1 / col 3 chatters every 3 cycles, then settles.
        n0 = a_code.size();
        for (int i = 0; i < 14; i++) begin
            pressed = (i % 2 == 0) ? kbit(1, 3) : '0;
            ticks(3);
        end
        chk("bounce_no_event", a_code.size() - n0, 0, 0);
        pressed = kbit(1, 3);
        wait_ev(n0, 40, ok);
        chk("bounce_event_seen", int'(ok), 1, 1);
        if (ok) chk("bounce_code", a_code[n0], 7, 7);
        ticks(20);
        chk("bounce_single_event", a_code.size() - n0, 1, 1);
        pressed = '0;
        wait_held(1'b0, 30, ok);

        // Auto-repeat on dut_b, none on dut_a.
        n0 = a_code.size();
        nb0 = b_cyc.size();
        pressed = kbit(1, 1);
        wait_ev(n0, 40, ok);
        chk("rep_event_seen", int'(ok), 1, 1);
        ta = (b_cyc.size() > nb0) ? b_cyc[nb0] : cyc;
        for (int i = 0; i < 100 && cyc < ta + 72; i++) tick();
        pressed = '0;
        wait_held(1'b0, 30, ok);
        chk("rep_release_seen", int'(ok), 1, 1);
        chk("rep_b_pulses", b_cyc.size() - nb0, 5, 5);
        for (int i = 0; i < 5 && nb0 + i < b_cyc.size(); i++) begin
            chk("rep_b_offset", b_cyc[nb0 + i] - ta, exp_off[i], exp_off[i]);
            chk("rep_b_code", b_code[nb0 + i], 5, 5);
        end
        chk("rep_a_pulses", a_code.size() - n0, 1, 1);

        // Reset while debouncing.
        n0 = a_code.size();
        wait_row(4'b0001, 20, ok);
        pressed = kbit(3, 2);
        wait_row(4'b1000, 20, ok);
        chk("rst_db_row_seen", int'(ok), 1, 1);
        ticks(5);
        #1 reset = 1'b1;
        #1 chk_reset_vals("rst_db");
        ticks(3);
        pressed = '0;
        reset = 1'b0;
        ticks(15);
        chk("rst_db_no_event", a_code.size() - n0, 0, 0);

        // Reset while held; key stays down so it is re-accepted normally afterwards.
        n0 = a_code.size();
        pressed = kbit(3, 2);
        wait_ev(n0, 40, ok);
        chk("rst_held_event_seen", int'(ok), 1, 1);
        if (ok) chk("rst_held_code", a_code[n0], 14, 14);
        ticks(3);
        #1 reset = 1'b1;
        #1 chk_reset_vals("rst_held");
        ticks(3);
        reset = 1'b0;
        ticks(6);
        chk("rst_release_no_event", a_code.size() - n0, 1, 1);
        wait_ev(n0 + 1, 40, ok);
        chk("rst_reaccept_seen", int'(ok), 1, 1);
        if (ok) chk("rst_reaccept_code", a_code[n0 + 1], 14, 14);
        pressed = '0;
        wait_held(1'b0, 30, ok);

        // Random presses, glitches and same-row double presses.
        for (int s = 0; s < 12; s++) begin
            k = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            g = $urandom_range(25, 40);
            c2 = (k % 4 + 1 + $urandom_range(0, 2)) % 4;
            n0 = a_code.size();
            m0 = a_merr;
            h = (kind == 0) ? $urandom_range(30, 60) : (kind == 1) ? $urandom_range(1, 4) : 40;
            pressed = kbit(k / 4, k % 4) | ((kind == 2) ? kbit(k / 4, c2) : '0);
            ticks(h);
            pressed = '0;
            ticks(g);
            chk("rand_events", a_code.size() - n0, (kind == 0) ? 1 : 0, (kind == 0) ? 1 : 0);
            if (kind == 0 && a_code.size() > n0) begin
                chk("rand_code", a_code[n0], k, k);
                chk("rand_row", a_row[n0], k / 4, k / 4);
                chk("rand_col", a_col[n0], k % 4, k % 4);
            end
            if (kind == 2) chk("rand_multi_err", a_merr - m0, 1, 100);
            chk("rand_held_clear", int'(ifa.key_held), 0, 0);
        end

        chk("valid_and_multi_err_together", both_cnt, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
